// File: rtl/pipe_register_if.sv
// Valid/ready handshake bundle for pipe_register: upstream input side, downstream
// output side, synchronous flush and the occupancy count.
interface pipe_register_if #(
    parameter int N      = 4,
    parameter int STAGES = 2
);
    localparam int CW = $clog2(STAGES + 1);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_register.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, backpressure,
// synchronous flush and a registered occupancy count.
module pipe_register #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_register_if.slave    bus
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d;
    logic [N-1:0]      d_q [STAGES];
    logic [N-1:0]      d_d [STAGES];
    logic [CW-1:0]     count_q, count_d;
    logic [STAGES-1:0] adv;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    // A stage may advance if it is empty or everything ahead of it can move.
    always_comb begin
        logic run;
        adv = '0;
        run = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            run    = !v_q[i] || run;
            adv[i] = run;
        end
    end

    assign in_ready = adv[0] && !bus.flush && reset_n;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = v_q[STAGES-1] && bus.out_ready;

    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q;
        if (bus.flush) begin
            v_d     = '0;
            count_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_fire;
                if (in_fire) d_d[0] = bus.in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) d_d[i] = d_q[i-1];
                end
            end
            count_d = count_q + CW'(in_fire) - CW'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < STAGES; i++) d_q[i] <= d_d[i];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_data  = d_q[STAGES-1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_register.sv
// Drives a 3-stage and a 1-stage pipe_register with identical stimulus and checks
// both against a queue-of-items reference model.
module tb_pipe_register;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    pipe_register_if #(.N(8), .STAGES(3)) bus3 ();
    pipe_register_if #(.N(8), .STAGES(1)) bus1 ();

    pipe_register #(.N(8), .STAGES(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3.slave));
    pipe_register #(.N(8), .STAGES(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    typedef struct {
        logic [7:0] data;
        int         pos;
    } item_t;

    item_t      mq [2][$];
    logic [7:0] last_out [2];
    int         checks   = 0;
    int         failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic rn, input logic fl, input logic iv,
                        input logic [7:0] id, input logic ordy);
        @(negedge clk);
        reset_n       = rn;
        bus3.flush    = fl;  bus1.flush    = fl;
        bus3.in_valid = iv;  bus1.in_valid = iv;
        bus3.in_data  = id;  bus1.in_data  = id;
        bus3.out_ready = ordy; bus1.out_ready = ordy;
        #1;
        for (int m = 0; m < 2; m++) begin
            int         s;
            int         cnt;
            int         limit;
            logic       ov;
            logic       exp_ready;
            logic       o_ready, o_valid;
            logic [7:0] o_data;
            int         o_count;
            s = (m == 0) ? 3 : 1;
            if (m == 0) begin
                o_ready = bus3.in_ready; o_valid = bus3.out_valid;
                o_data  = bus3.out_data; o_count = int'(bus3.count);
            end else begin
                o_ready = bus1.in_ready; o_valid = bus1.out_valid;
                o_data  = bus1.out_data; o_count = int'(bus1.count);
            end
            cnt       = mq[m].size();
            ov        = (cnt > 0) && (mq[m][0].pos == s - 1);
            exp_ready = rn && !fl && ((cnt < s) || ordy);
            check_eq($sformatf("s%0d.in_ready", s),  32'(o_ready), 32'(exp_ready));
            check_eq($sformatf("s%0d.out_valid", s), 32'(o_valid), 32'(ov));
            check_eq($sformatf("s%0d.out_data", s),  32'(o_data),  32'(last_out[m]));
            check_eq($sformatf("s%0d.count", s),     32'(o_count), 32'(cnt));

            if (!rn) begin
                mq[m].delete();
                last_out[m] = 8'h00;
            end else begin
                if (ov && ordy) void'(mq[m].pop_front());
                if (fl) begin
                    mq[m].delete();
                end else begin
                    limit = s;
                    for (int k = 0; k < mq[m].size(); k++) begin
                        if (mq[m][k].pos + 1 < limit) begin
                            mq[m][k].pos = mq[m][k].pos + 1;
                            if (mq[m][k].pos == s - 1) last_out[m] = mq[m][k].data;
                        end
                        limit = mq[m][k].pos;
                    end
                    if (iv && exp_ready) begin
                        mq[m].push_back('{data: id, pos: 0});
                        if (s == 1) last_out[m] = id;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 8'h00, ordy);
    endtask

    initial begin
        last_out[0] = 8'h00;
        last_out[1] = 8'h00;
        reset_n = 1'b0;
        bus3.flush = 1'b0; bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0);

        for (int v = 1; v <= 10; v++) step(1'b1, 1'b0, 1'b1, 8'(v), 1'b1);
        idle(5, 1'b1);

        step(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hA3, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hA4, 1'b1);
        idle(5, 1'b1);

        step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 8'h30 + 8'(k), 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        idle(3, 1'b1);

        step(1'b1, 1'b0, 1'b1, 8'h61, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h62, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h63, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(4, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        idle(4, 1'b1);

        for (int ph = 0; ph < 4; ph++) begin
            int rdy_pct;
            rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 70;
            for (int c = 0; c < 300; c++) begin
                logic rn, fl, iv, ordy;
                rn   = ($urandom_range(0, 79) != 0);
                fl   = ($urandom_range(0, 39) == 0);
                iv   = ($urandom_range(0, 99) < 75);
                ordy = ($urandom_range(0, 99) < rdy_pct);
                step(rn, fl, iv, 8'($urandom_range(0, 255)), ordy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
